// File: rtl/bram_port_arbiter.sv
// Two-client round-robin arbiter in front of a simple-dual-port BRAM (independent read and write channels).
// Optional same-cycle write-to-read forwarding is enabled by defining BRAM_ARB_WR_FWD_EN.
module bram_port_arbiter #(
   parameter int unsigned WID_MEM = 1,
   parameter int unsigned ADDR_W  = 13
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               c0_req,
   input  logic               c0_we,
   input  logic [ADDR_W-1:0]  c0_addr,
   input  logic [WID_MEM-1:0] c0_wdata,
   output logic               c0_gnt,
   output logic               c0_rvalid,
   output logic [WID_MEM-1:0] c0_rdata,
   input  logic               c1_req,
   input  logic               c1_we,
   input  logic [ADDR_W-1:0]  c1_addr,
   input  logic [WID_MEM-1:0] c1_wdata,
   output logic               c1_gnt,
   output logic               c1_rvalid,
   output logic [WID_MEM-1:0] c1_rdata,
   output logic [ADDR_W-1:0]  mem_raddr,
   output logic [ADDR_W-1:0]  mem_waddr,
   output logic [WID_MEM-1:0] mem_din,
   output logic               mem_we,
   input  logic [WID_MEM-1:0] mem_dout
);

   logic rd_req0, rd_req1, wr_req0, wr_req1;
   logic rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1;
   logic rr_rd, rr_wr;
   logic rvalid0_q, rvalid1_q;
   logic [WID_MEM-1:0] rdata0_q, rdata1_q;
   logic [WID_MEM-1:0] rd_data;

   // Channel split and round-robin grant; rr==0 favours client 0 when contested
   always_comb begin
      rd_req0 = reset & c0_req & ~c0_we;
      rd_req1 = reset & c1_req & ~c1_we;
      wr_req0 = reset & c0_req & c0_we;
      wr_req1 = reset & c1_req & c1_we;
      rd_gnt0 = rd_req0 & (~rd_req1 | ~rr_rd);
      rd_gnt1 = rd_req1 & (~rd_req0 | rr_rd);
      wr_gnt0 = wr_req0 & (~wr_req1 | ~rr_wr);
      wr_gnt1 = wr_req1 & (~wr_req0 | rr_wr);
   end

   assign c0_gnt = rd_gnt0 | wr_gnt0;
   assign c1_gnt = rd_gnt1 | wr_gnt1;

   // RAM port muxes; idle channels drive zero
   always_comb begin
      mem_raddr = '0;
      mem_waddr = '0;
      mem_din   = '0;
      mem_we    = wr_gnt0 | wr_gnt1;
      if (rd_gnt0)      mem_raddr = c0_addr;
      else if (rd_gnt1) mem_raddr = c1_addr;
      if (wr_gnt0) begin
         mem_waddr = c0_addr;
         mem_din   = c0_wdata;
      end else if (wr_gnt1) begin
         mem_waddr = c1_addr;
         mem_din   = c1_wdata;
      end
   end

`ifdef BRAM_ARB_WR_FWD_EN
   logic               fwd_q;
   logic [WID_MEM-1:0] din_q;

   // A read colliding with a same-cycle write returns the new word
   always_ff @(posedge clk) begin
      if (!reset) begin
         fwd_q <= 1'b0;
         din_q <= '0;
      end else begin
         fwd_q <= (rd_gnt0 | rd_gnt1) & mem_we & (mem_raddr == mem_waddr);
         din_q <= mem_din;
      end
   end

   assign rd_data = fwd_q ? din_q : mem_dout;
`else
   assign rd_data = mem_dout;
`endif

   // A response due in a reset cycle is dropped
   assign c0_rvalid = rvalid0_q & reset;
   assign c1_rvalid = rvalid1_q & reset;
   assign c0_rdata  = c0_rvalid ? rd_data : rdata0_q;
   assign c1_rdata  = c1_rvalid ? rd_data : rdata1_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_rd     <= 1'b0;
         rr_wr     <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         if (rd_req0 & rd_req1) rr_rd <= ~rr_rd;
         if (wr_req0 & wr_req1) rr_wr <= ~rr_wr;
         rvalid0_q <= rd_gnt0;
         rvalid1_q <= rd_gnt1;
         if (c0_rvalid) rdata0_q <= rd_data;
         if (c1_rvalid) rdata1_q <= rd_data;
      end
   end

endmodule
